// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: shadow E/M/W destination tracking,
// forwarding selects, F/D stall, D/E flushes and saturating event counters.
// Define HAZARD_FORWARD_EN for forwarding; otherwise the unit interlocks on RAW hazards.
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic             RegWriteD,
   input  logic [1:0]       ResultSrcD,
   input  logic             PCSrcE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [4:0]       r_Rs1E, r_Rs2E, r_RdE, r_RdM, r_RdW;
   logic             r_RegWriteE, r_RegWriteM, r_RegWriteW;
   logic [1:0]       r_ResultSrcE;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   logic             w_hazard;
   logic             w_stall;
   logic             w_flushE;
   logic [1:0]       w_fwdA, w_fwdB;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + CNT_W'(1);
      return v;
   endfunction

`ifdef HAZARD_FORWARD_EN
   // M has priority over W; x0 is never a forwarding source.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdM, input logic wM,
                                          input logic [4:0] rdW, input logic wW);
      if (wM && (rdM != 5'd0) && (rdM == rs))
         return 2'b10;
      if (wW && (rdW != 5'd0) && (rdW == rs))
         return 2'b01;
      return 2'b00;
   endfunction

   assign w_hazard = (r_ResultSrcE == 2'b01) && r_RegWriteE && (r_RdE != 5'd0) &&
                     ((r_RdE == Rs1D) || (r_RdE == Rs2D));
   assign w_fwdA   = fwd_sel(r_Rs1E, r_RdM, r_RegWriteM, r_RdW, r_RegWriteW);
   assign w_fwdB   = fwd_sel(r_Rs2E, r_RdM, r_RegWriteM, r_RdW, r_RegWriteW);
`else
   // W is safe without an interlock: the register file writes before it reads.
   function automatic logic raw_dep(input logic [4:0] rs,
                                    input logic [4:0] rdE, input logic wE,
                                    input logic [4:0] rdM, input logic wM);
      return (rs != 5'd0) && ((wE && (rdE == rs)) || (wM && (rdM == rs)));
   endfunction

   logic w_unused;
   assign w_unused = ^{r_Rs1E, r_Rs2E, r_ResultSrcE};
   assign w_hazard = raw_dep(Rs1D, r_RdE, r_RegWriteE, r_RdM, r_RegWriteM) ||
                     raw_dep(Rs2D, r_RdE, r_RegWriteE, r_RdM, r_RegWriteM);
   assign w_fwdA   = 2'b00;
   assign w_fwdB   = 2'b00;
`endif

   // A taken branch overrides any stall.
   assign w_stall  = w_hazard && !PCSrcE;
   assign w_flushE = w_hazard || PCSrcE;

   assign StallF    = !rst && w_stall;
   assign StallD    = !rst && w_stall;
   assign FlushD    = !rst && PCSrcE;
   assign FlushE    = !rst && w_flushE;
   assign ForwardAE = rst ? 2'b00 : w_fwdA;
   assign ForwardBE = rst ? 2'b00 : w_fwdB;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // Shadow E/M/W stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_Rs1E       <= '0;
         r_Rs2E       <= '0;
         r_RdE        <= '0;
         r_RegWriteE  <= 1'b0;
         r_ResultSrcE <= '0;
         r_RdM        <= '0;
         r_RegWriteM  <= 1'b0;
         r_RdW        <= '0;
         r_RegWriteW  <= 1'b0;
      end else begin
         if (w_flushE) begin
            r_Rs1E       <= '0;
            r_Rs2E       <= '0;
            r_RdE        <= '0;
            r_RegWriteE  <= 1'b0;
            r_ResultSrcE <= '0;
         end else begin
            r_Rs1E       <= Rs1D;
            r_Rs2E       <= Rs2D;
            r_RdE        <= RdD;
            r_RegWriteE  <= RegWriteD;
            r_ResultSrcE <= ResultSrcD;
         end
         r_RdM       <= r_RdE;
         r_RegWriteM <= r_RegWriteE;
         r_RdW       <= r_RdM;
         r_RegWriteW <= r_RegWriteM;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_stall_cnt <= sat_inc(r_stall_cnt, w_stall);
         r_flush_cnt <= sat_inc(r_flush_cnt, PCSrcE);
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed per-cycle vectors push expected
// outputs into a queue; a monitor pops and compares on each sample event.
module tb_hazard_unit;

   localparam int CW = 3;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    Rs1D, Rs2D, RdD;
   logic          RegWriteD;
   logic [1:0]    ResultSrcD;
   logic          PCSrcE;
   logic          StallF, StallD, FlushD, FlushE;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_unit #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] v;
      string       nm;
   } exp_t;

   exp_t          exp_q[$];
   event          chk_ev;
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] m_sc = '0;
   logic [CW-1:0] m_fc = '0;

   // Monitor: {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,stall_cnt,flush_cnt}
   initial begin
      exp_t e;
      logic [13:0] act;
      forever begin
         @(chk_ev);
         act = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expect: got %b with empty scoreboard", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s: got %b required %b (SF SD FD FE FA FB sc fc)", e.nm, act, e.v);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic push_exp(input logic [13:0] v, input string nm);
      exp_t e;
      e.v  = v;
      e.nm = nm;
      exp_q.push_back(e);
   endtask

   // One cycle: drive D-stage inputs, expect stall st and the given forward selects.
   task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic [1:0] rsrc, input logic pc,
                      input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input string nm, input bit adv = 1'b1);
      Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc; PCSrcE = pc;
      push_exp({st, st, pc, st | pc, fa, fb, m_sc, m_fc}, nm);
      #2 ->chk_ev;
      if (st && m_sc != CMAX) m_sc = m_sc + 1'b1;
      if (pc && m_fc != CMAX) m_fc = m_fc + 1'b1;
      if (adv) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic nop(input string nm);
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, nm);
   endtask

   initial begin
      // Reset with a branch and a would-be hazard driven: everything must read 0.
      rst = 1'b1;
      Rs1D = 5'd5; Rs2D = 5'd5; RdD = 5'd5; RegWriteD = 1'b1; ResultSrcD = 2'b01; PCSrcE = 1'b1;
      #3;
      push_exp('0, "reset_a");
      ->chk_ev;
      @(posedge clk);
      #1;
      push_exp('0, "reset_b");
      #1 ->chk_ev;
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef HAZARD_FORWARD_EN
      cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "alu_add");
      cyc(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "alu_sub_inD");
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, "alu_fwdM");
      nop("alu_drain");
      cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "d2_add");
      nop("d2_nop");
      cyc(5'd1, 5'd5, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "d2_or_inD");
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, "d2_fwdW");
      cyc(5'd1, 5'd2, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "x0_add");
      nop("x0_nop");
      cyc(5'd1, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "x0_or_inD");
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "x0_no_fwd");
      cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "prio_add1");
      cyc(5'd3, 5'd4, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "prio_add2");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "prio_sub_inD");
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, "prio_M_over_W");
      cyc(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "lu_lw");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "lu_stall");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "lu_release");
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, "lu_fwdW");
      cyc(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, "br_taken");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "br_E_bubble");
      cyc(5'd1, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "brlu_lw");
      cyc(5'd7, 5'd0, 5'd8, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "brlu_pc_wins");
      nop("brlu_after");
      cyc(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "rs_lw");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "rs_stall", 1'b0);
`else
      cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "il_add");
      cyc(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "il_stall_E");
      cyc(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "il_stall_M");
      cyc(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "il_W_free");
      nop("il_drain");
      cyc(5'd1, 5'd2, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "x0_add");
      cyc(5'd1, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "x0_no_stall");
      nop("x0_nop");
      cyc(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "lu_lw");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "lu_stall_E");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "lu_stall_M");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "lu_release");
      nop("lu_nop");
      cyc(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, "br_taken");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "br_E_bubble");
      cyc(5'd1, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "brlu_lw");
      cyc(5'd7, 5'd0, 5'd8, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "brlu_pc_wins");
      nop("brlu_after");
      cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "rs_add");
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "rs_stall", 1'b0);
`endif
      // Reset in the middle of the stall cycle, no clock edge in between.
      #1 rst = 1'b1;
      push_exp('0, "rs_async_clear");
      #1 ->chk_ev;
      m_sc = '0;
      m_fc = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "rs_empty_pipe");
      nop("rs_no_fwd");
      nop("rs_nop");

      // Drive more taken branches than the counter can hold.
      for (int i = 0; i < 9; i++)
         cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, $sformatf("sat_br%0d", i));
      nop("sat_hold");

      #4;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
